uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8-bit asynchronous serial receiver: oversamples the UART RX line and delivers each received byte on a valid/ready handshake.
- Sits directly upstream of the RX FIFO inside the UART block. o_data/o_valid drive the FIFO write data/enable; i_ready is the FIFO's not-full.
- Frame format: 8N1, LSB first.

Parameters:
- Oversample, 16, oversample ticks per bit; even, >= 4.
- DivWidth, 16, width of the clock-divider input.

Ports:
- i_clk  in  1  system clock (one clock; reset is synchronous and active-high)
- i_rst  in  1  synchronous active-high reset
- i_clk_div  in  DivWidth  clocks per oversample tick minus 1
- i_rx  in  1  serial line, asynchronous, idle high
- o_data  out  8  received byte
- o_valid  out  1  o_data holds an unconsumed byte
- i_ready  in  1  consumer accepts o_data when o_valid & i_ready
- o_busy  out  1  state != IDLE
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_overrun  out  1  one-cycle pulse: byte completed while o_valid & ~i_ready

Behaviour:
- Reset:
  - o_data=0, o_valid=0, o_busy=0, o_frame_err=0, o_overrun=0.
  - Both synchronizer flops = 1; state=IDLE; all counters = 0.
- Synchronizer: i_rx passes through 2 flops (rx_s). Edge detection compares rx_s with its previous value.
- Tick generator:
  - Counter runs 0..i_clk_div; tick asserts for one cycle when count == i_clk_div, then the counter returns to 0.
  - Counter and the tick index (0..Oversample-1) are cleared on entry to START.
  - i_clk_div is latched on entry to START; changes mid-frame have no effect on that frame.
  - i_clk_div=0 gives a tick every cycle.
- States:
  - IDLE: rx_s falling edge (prev 1, now 0) -> START. A line held low does not retrigger.
  - START: at tick index Oversample/2-1 (mid-bit), rx_s=0 -> DATA; rx_s=1 -> IDLE (glitch rejected, no output).
  - DATA:
    - Samples at each mid-bit, i.e. every Oversample ticks after the start mid-sample.
    - Shifts right into the shift register (LSB first).
    - After 8 samples -> STOP.
  - STOP: at the mid-bit sample:
    - rx_s=1: byte complete -> IDLE.
    - rx_s=0: o_frame_err pulses, byte discarded -> IDLE.
    - The return to IDLE is immediate at mid-stop, so a start edge in the second half of the stop bit is accepted.
- Output handshake:
  - Byte complete with o_valid=0: o_data <= shift register and o_valid <= 1, both in the cycle after the stop sample.
  - o_valid holds, with o_data stable, until a cycle with i_ready=1; o_valid clears the following cycle.
  - Byte complete while o_valid=1:
    - If i_ready=1 in the same cycle, the new byte replaces the old one and o_valid stays 1.
    - Otherwise o_overrun pulses, the new byte is dropped, and the old byte is kept.
- Reset mid-frame: immediate return to the reset values. A partial byte is never output.
- Frame error and overrun can never pulse in the same cycle.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Adds input i_parity_odd (1 bit) and output o_parity_err (1-cycle pulse, reset 0).
  - Adds state PARITY between DATA and STOP, sampled mid-bit like a data bit.
  - If the XOR of the 8 data bits and the parity bit != i_parity_odd: o_parity_err pulses in the cycle after the stop sample and the byte is discarded.
  - Framing is still checked; a parity error and a frame error may pulse together.
- Undefined: no PARITY state, neither port exists, 8N1 only.

Test Plan (i_clk_div=3, Oversample=16 -> 64 clocks per bit):
1. Idle 200 cycles, then 0xA5 8N1, i_ready=1 -> exactly one o_valid cycle with o_data=0xA5, asserted within 2+4+64*9.5 clocks of the start edge.
2. Low glitch of 20 clocks, then high -> returns to IDLE within 40 clocks; o_valid, o_frame_err and o_overrun stay 0.
3. 0x3C with stop bit driven low, then line high -> single o_frame_err pulse, o_valid stays 0; the next byte 0x81 is received correctly.
4. Back-to-back 0x11 then 0x22, i_ready=0 -> o_data=0x11 held, one o_overrun pulse at 0x22 completion; then i_ready=1 -> 0x11 accepted, o_valid=0.
5. i_rst pulsed mid DATA bit 4 of 0xFF -> all outputs 0 the next cycle, no byte output; the following 0x5A is received correctly.
6. With UART_RX_PARITY_EN, i_parity_odd=0:
   - 0x07 with parity bit 1 -> accepted.
   - 0x07 with parity bit 0 -> o_parity_err pulse, no o_valid.

Source files
------------

// File: rtl/uart_rx.sv
// 8-bit oversampling UART receiver (8N1, LSB first) with valid/ready output.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx #(
    parameter int Oversample = 16,
    parameter int DivWidth   = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [DivWidth-1:0] i_clk_div,
    input  logic                i_rx,
`ifdef UART_RX_PARITY_EN
    input  logic                i_parity_odd,
    output logic                o_parity_err,
`endif
    output logic [7:0]          o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_busy,
    output logic                o_frame_err,
    output logic                o_overrun
);

    localparam int IdxW = (Oversample > 1) ? $clog2(Oversample) : 1;
    localparam logic [IdxW-1:0] MidIdx  = IdxW'(Oversample / 2 - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Oversample - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state, state_nxt;

    logic                rx_m, rx_s, rx_prev;
    logic [DivWidth-1:0] div_q, cnt;
    logic [IdxW-1:0]     idx;
    logic [2:0]          bit_cnt;
    logic [7:0]          shreg;
    logic                tick, mid;
    logic                start_go, shift, stop_smp;
    logic                frm_bad, par_bad, byte_done;

    assign tick   = (cnt == div_q);
    assign mid    = tick && (idx == MidIdx);
    assign o_busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        shift     = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            IDLE: begin
                // Only a 1->0 transition starts a frame; a stuck-low line does not.
                if (rx_prev && !rx_s) begin
                    state_nxt = START;
                    start_go  = 1'b1;
                end
            end
            START: if (mid) state_nxt = rx_s ? IDLE : DATA;
            DATA: begin
                if (mid) begin
                    shift = 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (mid) state_nxt = STOP;
`endif
            STOP: begin
                if (mid) begin
                    stop_smp  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign par_bad = stop_smp && ((^shreg ^ par_bit) != i_parity_odd);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            par_bit      <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            if (state == PARITY && mid) par_bit <= rx_s;
            o_parity_err <= par_bad;
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    assign frm_bad   = stop_smp && !rx_s;
    assign byte_done = stop_smp && rx_s && !par_bad;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev     <= 1'b1;
            div_q       <= '0;
            cnt         <= '0;
            idx         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            rx_m    <= i_rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;

            // Divider is latched per frame so mid-frame rate changes cannot skew it.
            if (start_go) begin
                cnt     <= '0;
                idx     <= '0;
                bit_cnt <= '0;
                div_q   <= i_clk_div;
            end else if (state != IDLE) begin
                if (tick) begin
                    cnt <= '0;
                    idx <= (idx == LastIdx) ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            if (shift) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end

            o_frame_err <= frm_bad;
            o_overrun   <= 1'b0;
            if (byte_done) begin
                // A simultaneous accept frees the slot, so the new byte replaces the old.
                if (!o_valid || i_ready) begin
                    o_data  <= shreg;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean bytes, glitch, framing error, overrun, reset.
module tb_uart_rx;

    localparam int OS      = 16;
    localparam int DIV     = 3;
    localparam int BIT_CLK = (DIV + 1) * OS;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int LAT_MAX = 6 + BIT_CLK * (2 * NB - 1) / 2;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [15:0] i_clk_div = 16'(DIV);
    logic        i_rx = 1'b1;
    logic        i_ready = 1'b1;
    logic [7:0]  o_data;
    logic        o_valid, o_busy, o_frame_err, o_overrun;
`ifdef UART_RX_PARITY_EN
    logic        i_parity_odd = 1'b0;
    logic        o_parity_err;
    bit          par_flip = 1'b0;
    int          pe_n = 0;
`endif

    uart_rx #(.Oversample(OS), .DivWidth(16)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clk_div   (i_clk_div),
        .i_rx        (i_rx),
`ifdef UART_RX_PARITY_EN
        .i_parity_odd(i_parity_odd),
        .o_parity_err(o_parity_err),
`endif
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0, v_cyc = 0, acc = 0, fe_n = 0, ov_n = 0, lat_cyc = 0;
    logic v_prev = 1'b0;
    logic [7:0] last_acc = 8'h00;

    // Event monitor, sampled on the falling edge away from DUT updates.
    always @(negedge i_clk) begin
        if (o_valid) v_cyc <= v_cyc + 1;
        if (o_valid && !v_prev) lat_cyc <= cyc;
        v_prev <= o_valid;
        if (o_valid && i_ready) begin
            acc      <= acc + 1;
            last_acc <= o_data;
        end
        if (o_frame_err) fe_n <= fe_n + 1;
        if (o_overrun) ov_n <= ov_n + 1;
`ifdef UART_RX_PARITY_EN
        if (o_parity_err) pe_n <= pe_n + 1;
`endif
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        i_rx = v;
        clk_wait(BIT_CLK);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b ^ par_flip);
`endif
        send_bit(stp);
        i_rx = 1'b1;
    endtask

    int a0, v0, f0, o0, c0;
    task automatic snap();
        a0 = acc; v0 = v_cyc; f0 = fe_n; o0 = ov_n; c0 = cyc;
    endtask

    initial begin
        clk_wait(4);
        i_rst = 1'b0;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ferr", 32'(o_frame_err), 32'd0);
        chk("rst_ovr", 32'(o_overrun), 32'd0);
`ifdef UART_RX_PARITY_EN
        chk("rst_perr", 32'(o_parity_err), 32'd0);
`endif

        // 1: clean byte with consumer ready
        clk_wait(200);
        snap();
        send_frame(8'hA5, 1'b1);
        clk_wait(20);
        chk("t1_acc", 32'(acc - a0), 32'd1);
        chk("t1_data", 32'(last_acc), 32'hA5);
        chk("t1_vcyc", 32'(v_cyc - v0), 32'd1);
        chk("t1_lat", 32'((lat_cyc - c0 >= 600) && (lat_cyc - c0 <= LAT_MAX)), 32'd1);
        chk("t1_ferr", 32'(fe_n - f0), 32'd0);

        // 2: short low glitch is rejected at mid start bit
        snap();
        i_rx = 1'b0;
        clk_wait(10);
        chk("t2_busy", 32'(o_busy), 32'd1);
        clk_wait(10);
        i_rx = 1'b1;
        clk_wait(20);
        chk("t2_idle", 32'(o_busy), 32'd0);
        chk("t2_vcyc", 32'(v_cyc - v0), 32'd0);
        chk("t2_ferr", 32'(fe_n - f0), 32'd0);
        chk("t2_ovr", 32'(ov_n - o0), 32'd0);

        // 3: framing error, then recovery
        snap();
        send_frame(8'h3C, 1'b0);
        clk_wait(BIT_CLK);
        chk("t3_ferr", 32'(fe_n - f0), 32'd1);
        chk("t3_vcyc", 32'(v_cyc - v0), 32'd0);
        snap();
        send_frame(8'h81, 1'b1);
        clk_wait(20);
        chk("t3_acc", 32'(acc - a0), 32'd1);
        chk("t3_data", 32'(last_acc), 32'h81);

        // 4: back-to-back with consumer stalled -> overrun, first byte kept
        i_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        clk_wait(20);
        chk("t4_valid", 32'(o_valid), 32'd1);
        chk("t4_data", 32'(o_data), 32'h11);
        chk("t4_ovr", 32'(ov_n - o0), 32'd1);
        chk("t4_acc0", 32'(acc - a0), 32'd0);
        i_ready = 1'b1;
        clk_wait(1);
        chk("t4_clr", 32'(o_valid), 32'd0);
        chk("t4_acc", 32'(acc - a0), 32'd1);
        chk("t4_acc_data", 32'(last_acc), 32'h11);

        // 5: reset in the middle of data bit 4
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i_rx = 1'b1;
        clk_wait(BIT_CLK / 2);
        i_rst = 1'b1;
        clk_wait(1);
        i_rst = 1'b0;
        chk("t5_busy", 32'(o_busy), 32'd0);
        chk("t5_valid", 32'(o_valid), 32'd0);
        chk("t5_data", 32'(o_data), 32'd0);
        chk("t5_flags", 32'({o_frame_err, o_overrun}), 32'd0);
        clk_wait(BIT_CLK * 6);
        chk("t5_nobyte", 32'(acc - a0), 32'd0);
        snap();
        send_frame(8'h5A, 1'b1);
        clk_wait(20);
        chk("t5_acc", 32'(acc - a0), 32'd1);
        chk("t5_rx", 32'(last_acc), 32'h5A);

`ifdef UART_RX_PARITY_EN
        // 6: even parity (i_parity_odd=0)
        i_parity_odd = 1'b0;
        par_flip = 1'b0;
        snap();
        begin
            int p0 = pe_n;
            send_frame(8'h07, 1'b1);
            clk_wait(20);
            chk("t6_acc", 32'(acc - a0), 32'd1);
            chk("t6_data", 32'(last_acc), 32'h07);
            chk("t6_pe0", 32'(pe_n - p0), 32'd0);
            par_flip = 1'b1;
            snap();
            p0 = pe_n;
            send_frame(8'h07, 1'b1);
            clk_wait(20);
            chk("t6_pe1", 32'(pe_n - p0), 32'd1);
            chk("t6_vcyc", 32'(v_cyc - v0), 32'd0);
            chk("t6_ferr", 32'(fe_n - f0), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
